// File: rtl/mod_updown_counter_if.sv
// Handshake-free control/status bundle for mod_updown_counter.
// master drives control and observes status; slave is the counter.
interface mod_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap;

  modport master (
    output en,
    output up,
    output load,
    output load_val,
    input  count,
    input  tc,
    input  wrap
  );

  modport slave (
    input  en,
    input  up,
    input  load,
    input  load_val,
    output count,
    output tc,
    output wrap
  );
endinterface

// File: rtl/mod_updown_counter.sv
// Synchronous modulo-N up/down counter with load, tc and wrap flags.
// Define MOD_UPDOWN_COUNTER_SAT_EN for saturating instead of wrapping.
module mod_updown_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  mod_updown_counter_if.slave     bus
);

  localparam longint unsigned MAXMOD =
    64'd1 << WIDTH;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("mod_updown_counter: WIDTH out of range");
  end

  if (MODULUS < 2 || MODULUS > MAXMOD) begin : g_bad_mod
    $error("mod_updown_counter: MODULUS out of range");
  end

  // Largest legal count; always fits in WIDTH bits.
  localparam logic [WIDTH-1:0] LAST =
    WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;

  logic             w_at_last;
  logic             w_at_zero;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic [WIDTH-1:0] w_ld;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic             w_wrap_nxt;
  logic             w_tc;

  assign w_at_last = (r_count == LAST);
  assign w_at_zero = (r_count == '0);

  // Out-of-range load values clamp to the top of the range.
  assign w_ld = (bus.load_val > LAST) ? LAST
                                      : bus.load_val;

`ifdef MOD_UPDOWN_COUNTER_SAT_EN
  assign w_inc = w_at_last ? LAST : r_count + ONE;
  assign w_dec = w_at_zero ? '0   : r_count - ONE;
`else
  assign w_inc = w_at_last ? '0   : r_count + ONE;
  assign w_dec = w_at_zero ? LAST : r_count - ONE;
`endif

  // Next count/wrap: load beats enable, enable picks direction.
  always_comb begin
    w_cnt_nxt  = r_count;
    w_wrap_nxt = 1'b0;
    if (bus.load) begin
      w_cnt_nxt = w_ld;
    end else if (bus.en) begin
      if (bus.up) begin
        w_cnt_nxt  = w_inc;
        w_wrap_nxt = w_at_last;
      end else begin
        w_cnt_nxt  = w_dec;
        w_wrap_nxt = w_at_zero;
      end
    end
  end

  // Count and wrap registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_cnt_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  // Terminal count flags the edge that will wrap, for cascading.
  assign w_tc = bus.en & ~bus.load &
                (bus.up ? w_at_last : w_at_zero);

  assign bus.count = r_count;
  assign bus.wrap  = r_wrap;
  assign bus.tc    = w_tc;

endmodule
